// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port arbiter for pipeline writeback and MUL/DIV results
//
// Ports:
//   CLK, RESET                 clock; synchronous active-low reset
//   WB_VALID/WB_RD/WB_DATA     pipeline writeback request (no backpressure except PIPE_STALL)
//   MD_VALID/MD_RD/MD_DATA     MUL/DIV result, held stable by the producer until MD_READY
//   MD_READY                   MUL/DIV result accepted this cycle (combinational)
//   ISSUE_VALID/ISSUE_RD       MUL/DIV issue, marks ISSUE_RD busy
//   BUSY_MASK                  outstanding MUL/DIV destinations (bit 0 always 0)
//   PIPE_STALL                 registered; pipeline holds its WB request while high
//   WRITE_EN/INADDRESS/IN      registered register-file write port
module reg_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_DATA,
    input  logic        MD_VALID,
    input  logic [4:0]  MD_RD,
    input  logic [31:0] MD_DATA,
    output logic        MD_READY,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_RD,
    output logic [31:0] BUSY_MASK,
    output logic        PIPE_STALL,
    output logic        WRITE_EN,
    output logic [4:0]  INADDRESS,
    output logic [31:0] IN
);
    typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE_MD = 1'b1} state_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_next;
    logic        stall_next;
    logic [31:0] busy_next;
    logic        md_hs;
    logic        wr_take;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    // State register plus the registered write port and scoreboard
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= ST_NORMAL;
            starve_cnt <= 4'd0;
            PIPE_STALL <= 1'b0;
            WRITE_EN   <= 1'b0;
            INADDRESS  <= 5'd0;
            IN         <= 32'd0;
            BUSY_MASK  <= 32'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            PIPE_STALL <= stall_next;
            BUSY_MASK  <= busy_next;
            // x0 writes complete the handshake but never reach the file
            WRITE_EN   <= wr_take && (wr_rd != 5'd0);
            if (wr_take && (wr_rd != 5'd0)) begin
                INADDRESS <= wr_rd;
                IN        <= wr_data;
            end
        end
    end

    // Next-state logic: starvation counter, forced-MD entry/exit, scoreboard
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        stall_next      = PIPE_STALL;
        case (state)
            ST_NORMAL: begin
                if (md_hs) begin
                    starve_cnt_next = 4'd0;
                end else if (MD_VALID && WB_VALID) begin
                    if (starve_cnt == STARVE_LAST) begin
                        state_next      = ST_FORCE_MD;
                        stall_next      = 1'b1;
                        starve_cnt_next = 4'd0;
                    end else begin
                        starve_cnt_next = starve_cnt + 4'd1;
                    end
                end
            end
            ST_FORCE_MD: begin
                // Leaving only on a handshake: a dropped MD_VALID keeps the pipeline stalled
                if (md_hs) begin
                    state_next      = ST_NORMAL;
                    stall_next      = 1'b0;
                    starve_cnt_next = 4'd0;
                end
            end
            default: state_next = ST_NORMAL;
        endcase

        busy_next = BUSY_MASK;
        if (md_hs) begin
            busy_next[MD_RD] = 1'b0;
        end
        // Applied after the clear so a same-cycle reissue of that rd stays busy
        if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
            busy_next[ISSUE_RD] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Output logic: handshake and write-source selection
    always_comb begin
        MD_READY = 1'b0;
        wr_take  = 1'b0;
        wr_rd    = 5'd0;
        wr_data  = 32'd0;
        if (RESET) begin
            case (state)
                ST_NORMAL:   MD_READY = MD_VALID && !WB_VALID;
                ST_FORCE_MD: MD_READY = MD_VALID;
                default:     MD_READY = 1'b0;
            endcase
            if ((state == ST_NORMAL) && WB_VALID) begin
                wr_take = 1'b1;
                wr_rd   = WB_RD;
                wr_data = WB_DATA;
            end else if (MD_READY) begin
                wr_take = 1'b1;
                wr_rd   = MD_RD;
                wr_data = MD_DATA;
            end
        end
        md_hs = MD_READY;
    end
endmodule
